// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the three signal groups of the load/store unit: the request
//   handshake from the MEM stage, the single-cycle response, and the
//   word-aligned DataMemory port.
//
//   Modports:
//     slave  - the load/store unit itself (consumes req_*, mem_dout;
//              drives req_ready, resp_*, mem_addr/din/wen/ren)
//     master - the pipeline + memory side (the mirror image)
//
//   Parameter ADDR_W : byte-address width (matches DataMemory addr).
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
   parameter int ADDR_W = 10
) ();
   // request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   // response
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   // DataMemory
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [31:0]       mem_dout;
   logic              mem_wen;
   logic              mem_ren;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_addr, mem_din, mem_wen, mem_ren
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_addr, mem_din, mem_wen, mem_ren
   );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   MEM-stage load/store unit in front of a word-wide DataMemory with a
//   registered read port. Accepts one byte/halfword/word load or store per
//   request, performs read-modify-write for sub-word stores, and returns
//   sign/zero-extended load data with a one-cycle resp_valid strobe.
//   Byte lanes are big-endian: offset 0 is bits [31:24].
//
//   Ports:
//     clk    - clock, all state changes on the rising edge
//     reset  - asynchronous, active-high
//     bus    - load_store_unit_if.slave (request, response, DataMemory)
//
//   Configuration macro:
//     LSU_ALIGN_TRAP_EN - when defined, misaligned requests skip memory and
//                         complete with resp_err=1, resp_rdata=0. When
//                         undefined, the offending low address bits are
//                         cleared and the access proceeds; resp_err is 0.
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD, MRG, WR, FIN} state_t;

   state_t            state_reg;
   logic              we_reg;
   logic [1:0]        size_reg;
   logic              uns_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic              ready_reg;
   logic              ren_reg;
   logic              wen_reg;
   logic              resp_valid_reg;
   logic              err_reg;

   // Incoming address with the low bits that a halfword/word cannot use
   // cleared. Memory only ever sees the word address, so this matters for
   // lane selection only.
   logic [ADDR_W-1:0] addr_fix;
   always_comb begin
      addr_fix = bus.req_addr;
      if (bus.req_size[1])
         addr_fix[1:0] = 2'b00;
      else if (bus.req_size[0])
         addr_fix[0] = 1'b0;
   end

`ifdef LSU_ALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`endif

   // Strobes are registered alongside the state so each one is a clean
   // flop output that is high for exactly the state it belongs to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         we_reg         <= 1'b0;
         size_reg       <= 2'b00;
         uns_reg        <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= 32'h0;
         ready_reg      <= 1'b1;
         ren_reg        <= 1'b0;
         wen_reg        <= 1'b0;
         resp_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         ren_reg        <= 1'b0;
         wen_reg        <= 1'b0;
         resp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.req_valid) begin
                  we_reg    <= bus.req_we;
                  size_reg  <= bus.req_size;
                  uns_reg   <= bus.req_unsigned;
                  addr_reg  <= addr_fix;
                  wdata_reg <= bus.req_wdata;
                  ready_reg <= 1'b0;
`ifdef LSU_ALIGN_TRAP_EN
                  if (misaligned) begin
                     state_reg      <= FIN;
                     resp_valid_reg <= 1'b1;
                     err_reg        <= 1'b1;
                  end else
`endif
                  if (bus.req_we && bus.req_size[1]) begin
                     state_reg <= WR;
                     wen_reg   <= 1'b1;
                  end else begin
                     state_reg <= RD;
                     ren_reg   <= 1'b1;
                  end
               end
            end
            RD: begin
               if (we_reg) begin
                  state_reg <= MRG;
                  wen_reg   <= 1'b1;
               end else begin
                  state_reg      <= FIN;
                  resp_valid_reg <= 1'b1;
               end
            end
            MRG, WR: begin
               state_reg      <= FIN;
               resp_valid_reg <= 1'b1;
            end
            default: begin   // FIN
               state_reg <= IDLE;
               ready_reg <= 1'b1;
               err_reg   <= 1'b0;
            end
         endcase
      end
   end

   // Store data replicated into every lane it may land in, plus per-lane
   // enables (bit gi = byte offset gi); merge keeps unaddressed lanes.
   logic [1:0]  off;
   logic [3:0]  be;
   logic [31:0] sdata;
   logic [31:0] merged;
   assign off = addr_reg[1:0];

   always_comb begin
      if (size_reg[1]) begin
         be    = 4'b1111;
         sdata = wdata_reg;
      end else if (size_reg[0]) begin
         be    = off[1] ? 4'b1100 : 4'b0011;
         sdata = {wdata_reg[15:0], wdata_reg[15:0]};
      end else begin
         be    = 4'b0001 << off;
         sdata = {4{wdata_reg[7:0]}};
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[31-8*gi -: 8] = be[gi] ? sdata[31-8*gi -: 8]
                                              : bus.mem_dout[31-8*gi -: 8];
      end
   endgenerate

   logic [31:0] din;
   always_comb begin
      din = 32'h0;
      if (state_reg == WR)
         din = wdata_reg;
      else if (state_reg == MRG)
         din = merged;
   end

   // Load lane extraction and extension.
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] rdata;
   always_comb begin
      case (off)
         2'd0:    lane_b = bus.mem_dout[31:24];
         2'd1:    lane_b = bus.mem_dout[23:16];
         2'd2:    lane_b = bus.mem_dout[15:8];
         default: lane_b = bus.mem_dout[7:0];
      endcase
      lane_h = off[1] ? bus.mem_dout[15:0] : bus.mem_dout[31:16];
   end

   always_comb begin
      rdata = 32'h0;
      if (state_reg == FIN && !we_reg && !err_reg) begin
         if (size_reg[1])
            rdata = bus.mem_dout;
         else if (size_reg[0])
            rdata = {{16{~uns_reg & lane_h[15]}}, lane_h};
         else
            rdata = {{24{~uns_reg & lane_b[7]}}, lane_b};
      end
   end

   assign bus.req_ready  = ready_reg;
   assign bus.mem_ren    = ren_reg;
   assign bus.mem_wen    = wen_reg;
   assign bus.mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
   assign bus.mem_din    = din;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_rdata = rdata;
`ifdef LSU_ALIGN_TRAP_EN
   assign bus.resp_err   = err_reg;
`else
   assign bus.resp_err   = 1'b0;
`endif
endmodule
